// File: rtl/alu8.sv
// 8-bit registered ALU: 16 operations selected by FS, result and N/Zero/C/V/D
// flags captured on the rising clock edge; synchronous active-high reset.
module alu8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       FS,
    input  logic [2:0]       SH,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] IN,
    input  logic [WIDTH-1:0] INK,
    output logic [WIDTH-1:0] F,
    output logic             N,
    output logic             Zero,
    output logic             C,
    output logic             V,
    output logic             D
);

    typedef enum logic [3:0] {
        OP_PASS = 4'd0,  OP_INC = 4'd1,  OP_ADD = 4'd2,  OP_ADC  = 4'd3,
        OP_SUB  = 4'd4,  OP_DEC = 4'd5,  OP_AND = 4'd6,  OP_OR   = 4'd7,
        OP_XOR  = 4'd8,  OP_NOT = 4'd9,  OP_SHL = 4'd10, OP_SHR  = 4'd11,
        OP_ASR  = 4'd12, OP_ROL = 4'd13, OP_LDIN = 4'd14, OP_LDK = 4'd15
    } op_e;

    op_e              w_op;
    logic [WIDTH-1:0] w_addb;
    logic             w_cin;
    logic [WIDTH-1:0] w_sum;
    logic             w_co;
    logic             w_half;
    logic             w_ovf;
    logic [WIDTH-1:0] w_shl_f, w_shr_f, w_asr_f, w_rol_f;
    logic             w_shl_c, w_shr_c, w_asr_c;
    logic             w_sh_nz;
    logic [WIDTH-1:0] w_f;
    logic             w_c, w_v, w_d;

    logic [WIDTH-1:0] r_f;
    logic             r_n, r_zero, r_c, r_v, r_d;

    assign w_op = op_e'(FS);

    // Every arithmetic op is one adder: A + second addend + carry-in.
    always_comb begin
        w_addb = '0;
        w_cin  = 1'b0;
        unique case (w_op)
            OP_INC:  w_addb = WIDTH'(1);
            OP_ADD:  w_addb = B;
            OP_ADC:  begin w_addb = B;  w_cin = r_c;  end
            OP_SUB:  begin w_addb = ~B; w_cin = 1'b1; end
            OP_DEC:  w_addb = '1;
            default: w_addb = '0;
        endcase
    end

    assign {w_co, w_sum} = {1'b0, A} + {1'b0, w_addb} + {{WIDTH{1'b0}}, w_cin};
    // Carry into bit 4 recovered from the sum bit, avoiding a second nibble adder.
    assign w_half = w_sum[4] ^ A[4] ^ w_addb[4];
    assign w_ovf  = (A[WIDTH-1] == w_addb[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);

    // One extra bit below/above the operand catches the last bit shifted out.
    assign {w_shl_c, w_shl_f} = {1'b0, A} << SH;
    assign {w_shr_f, w_shr_c} = {A, 1'b0} >> SH;
    assign {w_asr_f, w_asr_c} = $signed({A, 1'b0}) >>> SH;
    assign w_rol_f = (A << SH) | (A >> (WIDTH - int'(SH)));
    assign w_sh_nz = (SH != 3'd0);

    always_comb begin
        w_f = A;
        w_c = 1'b0;
        w_v = 1'b0;
        w_d = 1'b0;
        unique case (w_op)
            OP_PASS: w_f = A;
            OP_INC, OP_ADD, OP_ADC, OP_SUB, OP_DEC: begin
                w_f = w_sum;
                w_c = w_co;
                w_v = w_ovf;
                w_d = w_half;
            end
            OP_AND:  w_f = A & B;
            OP_OR:   w_f = A | B;
            OP_XOR:  w_f = A ^ B;
            OP_NOT:  w_f = ~A;
            OP_SHL:  begin w_f = w_shl_f; w_c = w_sh_nz & w_shl_c; end
            OP_SHR:  begin w_f = w_shr_f; w_c = w_sh_nz & w_shr_c; end
            OP_ASR:  begin w_f = w_asr_f; w_c = w_sh_nz & w_asr_c; end
            OP_ROL:  begin w_f = w_rol_f; w_c = w_sh_nz & w_rol_f[0]; end
            OP_LDIN: w_f = IN;
            OP_LDK:  w_f = INK;
            default: w_f = A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_f    <= '0;
            r_n    <= 1'b0;
            r_zero <= 1'b0;
            r_c    <= 1'b0;
            r_v    <= 1'b0;
            r_d    <= 1'b0;
        end else begin
            r_f    <= w_f;
            r_n    <= w_f[WIDTH-1];
            r_zero <= (w_f == '0);
            r_c    <= w_c;
            r_v    <= w_v;
            r_d    <= w_d;
        end
    end

    assign F    = r_f;
    assign N    = r_n;
    assign Zero = r_zero;
    assign C    = r_c;
    assign V    = r_v;
    assign D    = r_d;

endmodule

// File: tb/tb_alu8.sv
// Self-checking bench for alu8: directed cases with fixed expectations plus
// randomized traffic against an integer-arithmetic reference model.
module tb_alu8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] fs;
    logic [2:0] sh;
    logic [7:0] a, b, inp, ink;
    logic [7:0] f;
    logic       n, zero, c, v, d;
    logic [12:0] obs;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0] f;
        logic n, z, c, v, d;
    } res_t;

    res_t exp_r;
    logic m_c;

    alu8 #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .FS(fs), .SH(sh), .A(a), .B(b), .IN(inp), .INK(ink),
        .F(f), .N(n), .Zero(zero), .C(c), .V(v), .D(d)
    );

    always #5 clk = ~clk;
    assign obs = {f, n, zero, c, v, d};

    function automatic int sgn(input int x);
        return (x > 127) ? x - 256 : x;
    endfunction

    function automatic res_t model(input int op, input int amt, input int ia, input int ib,
                                   input int iin, input int ik, input int cin);
        res_t r;
        int addend, ci, sum, sv;
        bit arith;
        logic [7:0] x;
        r = '0;
        arith = 0;
        addend = 0;
        ci = 0;
        x = 8'(ia);
        case (op)
            0:  x = 8'(ia);
            1:  begin arith = 1; addend = 1; end
            2:  begin arith = 1; addend = ib; end
            3:  begin arith = 1; addend = ib; ci = cin; end
            4:  begin arith = 1; addend = 255 - ib; ci = 1; end
            5:  begin arith = 1; addend = 255; end
            6:  x = 8'(ia & ib);
            7:  x = 8'(ia | ib);
            8:  x = 8'(ia ^ ib);
            9:  x = 8'(255 - ia);
            14: x = 8'(iin);
            15: x = 8'(ik);
            default: begin
                for (int k = 0; k < amt; k++) begin
                    case (op)
                        10: begin r.c = x[7]; x = {x[6:0], 1'b0}; end
                        11: begin r.c = x[0]; x = {1'b0, x[7:1]}; end
                        12: begin r.c = x[0]; x = {x[7], x[7:1]}; end
                        default: begin x = {x[6:0], x[7]}; r.c = x[0]; end
                    endcase
                end
            end
        endcase
        if (arith) begin
            sum = ia + addend + ci;
            x   = 8'(sum % 256);
            r.c = (sum > 255);
            r.d = ((ia % 16) + (addend % 16) + ci) > 15;
            sv  = sgn(ia) + sgn(addend) + ci;
            r.v = (sv > 127) || (sv < -128);
        end
        r.f = x;
        r.n = x[7];
        r.z = (x == 8'h00);
        return r;
    endfunction

    // Applies one cycle of inputs, clocks it in and advances the reference model.
    task automatic step(input logic r, input int op, input int amt, input int ia, input int ib,
                        input int iin, input int ik);
        rst = r; fs = 4'(op); sh = 3'(amt); a = 8'(ia); b = 8'(ib); inp = 8'(iin); ink = 8'(ik);
        if (r) exp_r = '0;
        else   exp_r = model(op, amt, ia, ib, iin, ik, int'(m_c));
        m_c = exp_r.c;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(0, 2, 0, 'hF6, 'h0A, 0, 0);
        total++;
        if (obs !== {8'h00, 5'b01101}) begin bad++; $display("FAIL reset_pre_add obs=%h exp=%h", obs, {8'h00, 5'b01101}); end
        step(1, 2, 0, 'hF6, 'h0A, 0, 0);
        total++;
        if (obs !== 13'h0) begin bad++; $display("FAIL reset_clear obs=%h exp=%h", obs, 13'h0); end
        step(0, 3, 0, 'h01, 'h01, 0, 0);
        total++;
        if (obs !== {8'h02, 5'b00000}) begin bad++; $display("FAIL reset_adc_cin obs=%h exp=%h", obs, {8'h02, 5'b00000}); end
    endtask

    task automatic test_arith_logic();
        int          ops[6] = '{2, 4, 6, 7, 8, 9};
        logic [12:0] ex[6]  = '{{8'h1D, 5'b00001}, {8'h01, 5'b00101}, {8'h0E, 5'b00000},
                                {8'h0F, 5'b00000}, {8'h01, 5'b00000}, {8'hF0, 5'b10000}};
        for (int i = 0; i < 6; i++) begin
            step(0, ops[i], 0, 'h0F, 'h0E, 0, 0);
            total++;
            if (obs !== ex[i]) begin bad++; $display("FAIL arith_logic fs=%0d obs=%h exp=%h", ops[i], obs, ex[i]); end
        end
    endtask

    task automatic test_wrap();
        step(0, 2, 0, 'hF6, 'h0A, 0, 0);
        total++;
        if (obs !== {8'h00, 5'b01101}) begin bad++; $display("FAIL wrap_add obs=%h exp=%h", obs, {8'h00, 5'b01101}); end
        step(0, 3, 0, 'hF6, 'h0A, 0, 0);
        total++;
        if (obs !== {8'h01, 5'b00101}) begin bad++; $display("FAIL wrap_adc obs=%h exp=%h", obs, {8'h01, 5'b00101}); end
    endtask

    task automatic test_overflow();
        int          ops[3] = '{1, 5, 5};
        int          av[3]  = '{'h7F, 'h80, 'h00};
        logic [12:0] ex[3]  = '{{8'h80, 5'b10011}, {8'h7F, 5'b00110}, {8'hFF, 5'b10000}};
        for (int i = 0; i < 3; i++) begin
            step(0, ops[i], 0, av[i], 'h55, 0, 0);
            total++;
            if (obs !== ex[i]) begin bad++; $display("FAIL overflow fs=%0d obs=%h exp=%h", ops[i], obs, ex[i]); end
        end
    endtask

    task automatic test_shifts();
        int          ops[5] = '{10, 11, 12, 13, 10};
        int          amt[5] = '{1, 1, 1, 1, 0};
        logic [12:0] ex[5]  = '{{8'h02, 5'b00100}, {8'h40, 5'b00100}, {8'hC0, 5'b10100},
                                {8'h03, 5'b00100}, {8'h81, 5'b10000}};
        for (int i = 0; i < 5; i++) begin
            step(0, ops[i], amt[i], 'h81, 'h00, 0, 0);
            total++;
            if (obs !== ex[i]) begin bad++; $display("FAIL shift fs=%0d sh=%0d obs=%h exp=%h", ops[i], amt[i], obs, ex[i]); end
        end
    endtask

    task automatic test_loads();
        step(0, 14, 0, 'h33, 'h44, 'h5A, 'hA5);
        total++;
        if (obs !== {8'h5A, 5'b00000}) begin bad++; $display("FAIL load_in obs=%h exp=%h", obs, {8'h5A, 5'b00000}); end
        step(0, 15, 0, 'h33, 'h44, 'h5A, 'h00);
        total++;
        if (obs !== {8'h00, 5'b01000}) begin bad++; $display("FAIL load_k obs=%h exp=%h", obs, {8'h00, 5'b01000}); end
    endtask

    task automatic test_sweep();
        res_t prev;
        for (int op = 0; op < 16; op++) begin
            prev = exp_r;
            rst = 0; fs = 4'(op); sh = 3'd1; a = 8'h0F; b = 8'h0E;
            #2;
            total++;
            if (obs !== prev) begin bad++; $display("FAIL sweep_early fs=%0d obs=%h exp=%h", op, obs, prev); end
            step(0, op, 1, 'h0F, 'h0E, 'hC3, 'h3C);
            total++;
            if (obs !== exp_r) begin bad++; $display("FAIL sweep fs=%0d obs=%h exp=%h", op, obs, exp_r); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 31) == 0), int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            total++;
            if (obs !== exp_r) begin
                bad++;
                $display("FAIL random i=%0d fs=%0d sh=%0d a=%h b=%h obs=%h exp=%h", i, fs, sh, a, b, obs, exp_r);
            end
        end
    endtask

    initial begin
        m_c = 1'b0;
        exp_r = '0;
        step(1, 0, 0, 0, 0, 0, 0);
        total++;
        if (obs !== 13'h0) begin bad++; $display("FAIL initial_reset obs=%h exp=%h", obs, 13'h0); end
        test_reset();
        test_arith_logic();
        test_wrap();
        test_overflow();
        test_shifts();
        test_loads();
        test_sweep();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
